// File: rtl/spi_slave_regbank.sv
// rtl/spi_slave_regbank.sv - SPI mode-0 slave exposing NREG write/read registers
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sclk, cs, mosi    asynchronous SPI pins (cs active low, MSB first)
//   miso              SPI read data, idles at 1
//   rd_data           packed read-back values, register i at [i*NBIT +: NBIT]
//   out               packed written register contents, same packing
//   wr                per-register write request, set on a completed write
//   wr_ack            per-register acknowledge, clears the matching wr bit
module spi_slave_regbank #(
    parameter int              NBIT     = 32,
    parameter int              NREG     = 4,
    parameter logic [6:0]      BASE_ADR = 7'd1,
    parameter logic [NBIT-1:0] RST_VAL  = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 cs,
    input  logic                 mosi,
    output logic                 miso,
    input  logic [NREG*NBIT-1:0] rd_data,
    output logic [NREG*NBIT-1:0] out,
    output logic [NREG-1:0]      wr,
    input  logic [NREG-1:0]      wr_ack
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] RDATA = 3'd3;
    localparam logic [2:0] SKIP  = 3'd4;

    logic [2:0]      sclk_sync;
    logic [2:0]      cs_sync;
    logic [2:0]      mosi_sync;
    logic [2:0]      state;
    logic [5:0]      cnt;
    logic [6:0]      hdr;
    logic [NBIT-1:0] shreg;
    logic [IW-1:0]   idx;

    logic            sclk_rise;
    logic            sclk_fall;
    logic            cs_fall;
    logic            cs_rise;
    logic            mosi_s;
    logic [7:0]      hdr_word;
    logic [7:0]      diff;
    logic            hit;
    logic [IW-1:0]   idx_new;
    logic [NBIT-1:0] wr_word;

    // Reset loads the current pin level into every stage so that leaving
    // reset in the middle of a frame never fabricates a cs or sclk edge;
    // the rest of such a frame is then ignored until the next cs fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {3{sclk}};
            cs_sync   <= {3{cs}};
            mosi_sync <= {3{mosi}};
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs};
            mosi_sync <= {mosi_sync[1:0], mosi};
        end
    end

    always_comb begin
        sclk_rise = sclk_sync[1] & ~sclk_sync[2];
        sclk_fall = ~sclk_sync[1] & sclk_sync[2];
        cs_fall   = ~cs_sync[1] & cs_sync[2];
        cs_rise   = cs_sync[1] & ~cs_sync[2];
        mosi_s    = mosi_sync[2];
        hdr_word  = {hdr, mosi_s};
        // 8-bit difference: bit 7 set means the address lies below the window.
        diff      = {1'b0, hdr_word[6:0]} - {1'b0, BASE_ADR};
        hit       = !diff[7] && (diff < 8'(NREG));
        idx_new   = diff[IW-1:0];
        wr_word   = {shreg[NBIT-2:0], mosi_s};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hdr   <= '0;
            shreg <= '0;
            idx   <= '0;
            miso  <= 1'b1;
            out   <= {NREG{RST_VAL}};
            wr    <= '0;
        end else begin
            // A set further down overrides this clear for the same bit.
            wr <= wr & ~wr_ack;
            if (cs_fall) begin
                state <= HDR;
                cnt   <= '0;
                miso  <= 1'b1;
            end else if (cs_rise) begin
                state <= IDLE;
                cnt   <= '0;
                miso  <= 1'b1;
            end else begin
                case (state)
                    HDR: begin
                        if (sclk_rise) begin
                            hdr <= hdr_word[6:0];
                            if (cnt == 6'd7) begin
                                cnt <= '0;
                                if (hit) begin
                                    idx <= idx_new;
                                    if (hdr_word[7]) begin
                                        state <= WDATA;
                                    end else begin
                                        state <= RDATA;
                                        shreg <= rd_data[idx_new*NBIT +: NBIT];
                                    end
                                end else begin
                                    state <= SKIP;
                                end
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            shreg <= wr_word;
                            cnt   <= cnt + 6'd1;
                            if (cnt == 6'(NBIT - 1)) begin
                                out[idx*NBIT +: NBIT] <= wr_word;
                                wr[idx]               <= 1'b1;
                                state                 <= SKIP;
                            end
                        end
                    end
                    RDATA: begin
                        // The LSB is held through the final rise; the fall
                        // after it returns miso to idle.
                        if (sclk_fall) begin
                            if (cnt == 6'(NBIT)) begin
                                miso  <= 1'b1;
                                state <= SKIP;
                            end else begin
                                miso  <= shreg[NBIT-1];
                                shreg <= {shreg[NBIT-2:0], 1'b0};
                                cnt   <= cnt + 6'd1;
                            end
                        end
                    end
                    IDLE, SKIP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// tb/tb_spi_slave_regbank.sv - table-driven bench for spi_slave_regbank
module tb_spi_slave_regbank;

    localparam int NBIT = 32;
    localparam int NREG = 4;
    localparam int HALF = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sclk;
    logic                 cs;
    logic                 mosi;
    logic                 miso;
    logic [NREG*NBIT-1:0] rd_data;
    logic [NREG*NBIT-1:0] out;
    logic [NREG-1:0]      wr;
    logic [NREG-1:0]      wr_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_slave_regbank #(
        .NBIT(NBIT),
        .NREG(NREG),
        .BASE_ADR(7'd1),
        .RST_VAL({NBIT{1'b1}})
    ) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .cs(cs),
        .mosi(mosi),
        .miso(miso),
        .rd_data(rd_data),
        .out(out),
        .wr(wr),
        .wr_ack(wr_ack)
    );

    typedef struct {
        logic [7:0]   hdr;
        logic [31:0]  data;
        int           nbits;
        logic [3:0]   ack;
        logic [127:0] exp_out;
        logic [3:0]   exp_wr;
        logic         chk_rx;
        logic [31:0]  exp_rx;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI bit; miso is captured just before the rising edge. A nonzero
    // ack_at_rise is driven for exactly the clk in which the slave acts on
    // this rise (three clk edges after the pin edge).
    task automatic spi_bit(input logic b, input logic [3:0] ack_at_rise, output logic rx);
        mosi = b;
        wait_clk(HALF);
        rx   = miso;
        sclk = 1'b1;
        if (ack_at_rise != 4'b0) begin
            wait_clk(2);
            wr_ack = ack_at_rise;
            wait_clk(1);
            wr_ack = 4'b0;
            wait_clk(HALF - 3);
        end else begin
            wait_clk(HALF);
        end
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] h, input logic [31:0] d, input int nbits,
                             input logic [3:0] last_ack, output logic [31:0] rx);
        logic b;
        rx = '0;
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 8; i++) spi_bit(h[7-i], 4'b0, b);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(d[31-i], (i == nbits - 1) ? last_ack : 4'b0, b);
            rx = {rx[30:0], b};
        end
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(8);
    endtask

    logic [31:0]  rx;
    logic [127:0] exp_o;

    initial begin
        rst     = 1'b1;
        sclk    = 1'b0;
        cs      = 1'b1;
        mosi    = 1'b0;
        wr_ack  = 4'b0;
        rd_data = {32'hA5A5000F, 32'h33333333, 32'h22222222, 32'h11111111};

        //          hdr    data          n   ack      exp_out {r3,r2,r1,r0}                                      exp_wr   rx?  exp_rx
        vecs[0] = '{8'h83, 32'h12345678, 32, 4'b0000, {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0100, 1'b1, 32'hFFFFFFFF};
        vecs[1] = '{8'h04, 32'h00000000, 32, 4'b0100, {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0000, 1'b1, 32'hA5A5000F};
        vecs[2] = '{8'h85, 32'hCAFEF00D, 32, 4'b0000, {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0000, 1'b1, 32'hFFFFFFFF};
        vecs[3] = '{8'h81, 32'h0BADF00D, 20, 4'b0000, {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0000, 1'b0, 32'h0};
        vecs[4] = '{8'h81, 32'hDEADBEEF, 32, 4'b0000, {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF}, 4'b0001, 1'b0, 32'h0};
        vecs[5] = '{8'h01, 32'h00000000, 32, 4'b0001, {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF}, 4'b0000, 1'b1, 32'h11111111};
        vecs[6] = '{8'h00, 32'h00000000, 32, 4'b0000, {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF}, 4'b0000, 1'b1, 32'hFFFFFFFF};
        vecs[7] = '{8'h84, 32'h0F0F0F0F, 32, 4'b0000, {32'h0F0F0F0F, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF}, 4'b1000, 1'b0, 32'h0};
        vecs[8] = '{8'h02, 32'h00000000, 32, 4'b1000, {32'h0F0F0F0F, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF}, 4'b0000, 1'b1, 32'h22222222};

        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        chk("reset_out", out, {4{32'hFFFFFFFF}});
        chk("reset_wr", 128'(wr), 128'(4'b0000));
        chk("reset_miso", 128'(miso), 128'(1'b1));

        for (int v = 0; v < 9; v++) begin
            spi_frame(vecs[v].hdr, vecs[v].data, vecs[v].nbits, 4'b0, rx);
            wr_ack = vecs[v].ack;
            wait_clk(1);
            wr_ack = 4'b0;
            wait_clk(1);
            chk($sformatf("v%0d_out", v), out, vecs[v].exp_out);
            chk($sformatf("v%0d_wr", v), 128'(wr), 128'(vecs[v].exp_wr));
            chk($sformatf("v%0d_miso_idle", v), 128'(miso), 128'(1'b1));
            if (vecs[v].chk_rx) chk($sformatf("v%0d_rx", v), 128'(rx), 128'(vecs[v].exp_rx));
        end

        // Write to reg1, then a second write whose completion coincides with wr_ack[1].
        exp_o = {32'h0F0F0F0F, 32'h12345678, 32'hAAAA5555, 32'hDEADBEEF};
        spi_frame(8'h82, 32'hAAAA5555, 32, 4'b0, rx);
        chk("first_wr1_out", out, exp_o);
        chk("first_wr1_wr", 128'(wr), 128'(4'b0010));

        exp_o = {32'h0F0F0F0F, 32'h12345678, 32'h5555AAAA, 32'hDEADBEEF};
        spi_frame(8'h82, 32'h5555AAAA, 32, 4'b0010, rx);
        chk("coincide_out", out, exp_o);
        chk("coincide_wr", 128'(wr), 128'(4'b0010));

        wr_ack = 4'b0010;
        wait_clk(1);
        wr_ack = 4'b0;
        chk("final_ack_wr", 128'(wr), 128'(4'b0000));
        chk("final_out", out, exp_o);

        // Reset in the middle of a write frame discards it and ignores the rest.
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 12; i++) spi_bit(i[0], 4'b0, rx[0]);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        for (int i = 0; i < 28; i++) spi_bit(1'b1, 4'b0, rx[0]);
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(8);
        chk("midreset_out", out, {4{32'hFFFFFFFF}});
        chk("midreset_wr", 128'(wr), 128'(4'b0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_regbank.md
# spi_slave_regbank

Parametrised SPI slave register bank that generalises our single-register SPI write block to NREG registers of NBIT bits each, with SPI read-back and per-register write-request/acknowledge handshakes. It sits between the board SPI master (MCU) and the FPGA control logic. It decodes an address byte against a contiguous address window, writes into the addressed register, and shifts out a register's read value on miso.

## Interface
Parameters:
- NBIT, 32 — data width per register (8..32).
- NREG, 4 — number of registers (1..16).
- BASE_ADR, 1 — 7-bit SPI address of register 0; register i answers at BASE_ADR+i.
- RST_VAL, all ones — reset value of every register.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous, mode 0 (idle low, sample on rising edge).
- cs  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out; 1 when not driving read data.
- rd_data  in  NREG*NBIT  read-back values; register i occupies bits [i*NBIT +: NBIT].
- out  out  NREG*NBIT  written register contents, same packing as rd_data.
- wr  out  NREG  per-register write request; set on a completed write.
- wr_ack  in  NREG  per-register acknowledge; clears the matching wr bit.

## Operation
- sclk, cs and mosi each pass through a 3-flop synchronizer.
- Edges are detected on stages [2:1]. mosi is sampled from stage 2 on a detected sclk rise.
- Frame = cs fall, then 8-bit header (bit7 R/W: 1 = write, 0 = read; bits6:0 = address), then NBIT data bits, then cs rise.
- FSM states:
  - IDLE: entered on reset and on any cs rise.
  - HDR: entered on cs fall from any state; header bit counter cleared.
  - WDATA: entered after the 8th header bit when the write address hits the window.
  - RDATA: entered after the 8th header bit when the read address hits the window.
  - SKIP: entered on an address miss, or after a frame completes. Stays there until cs rises.
- Window hit: BASE_ADR <= adr <= BASE_ADR+NREG-1, using 7-bit unsigned compare. idx = adr - BASE_ADR.
- WDATA:
  - Shift in NBIT bits.
  - On the NBIT-th rise: out[idx] <= shifted word, wr[idx] <= 1, then go to SKIP.
- RDATA:
  - On header completion, load rd_data[idx] into the NBIT-bit output shifter; miso stays 1.
  - On each following detected sclk fall, miso <= shifter MSB and the shifter shifts left.
  - After NBIT falls, go to SKIP.
- miso = 1 in IDLE, HDR, WDATA and SKIP.
- cs rise before the frame completes: abort. No register change, no wr set, go to IDLE.
- cs fall while in any state: restart in HDR.
- Extra sclk edges after a frame completes are ignored (SKIP).
- wr[i]:
  - Set by a completed write; stays set until wr_ack[i]=1 for one clk.
  - If set and ack coincide in the same clk, set wins.
  - A second write before ack overwrites out[i]; wr[i] stays 1.
- Reset: out = RST_VAL replicated, wr = 0, miso = 1, FSM in IDLE, all counters and shifters cleared. A reset during a frame discards it. The remainder of that frame is ignored until the next cs fall.

## Timing
- sclk high and low phases must each be >= 4 clk; cs setup to the first sclk rise must be >= 4 clk.
- Write latency: out[idx] and wr[idx] update on the clk edge after the detected rise of the last data bit. That is 3–4 clk after the pin edge.
- wr_ack is registered-in: wr[i] reads 0 on the clk after the ack cycle.
- Read: rd_data[idx] is sampled in the clk in which the 8th header rise is detected. The MSB appears on miso 3–4 clk after the 8th sclk fall, so it is valid before the 9th rise.
- rd_data changes after the sample point do not affect the current frame.

## Test plan
- Reset with NBIT=32, NREG=4, BASE_ADR=1 -> out = 0xFFFFFFFF x4, wr = 0000, miso = 1.
- Write header 0x83 with data 0x12345678 -> out[2] = 0x12345678, wr = 0100. Pulse wr_ack[2] -> wr = 0000. Other registers unchanged.
- Read header 0x04 with rd_data[3] = 0xA5A5000F -> miso shifts out 0xA5A5000F MSB-first on the falling edges; miso = 1 after the frame.
- Header 0x85 (address out of window) plus 32 bits -> no change to out or wr; miso stays 1.
- Write header 0x81 with cs raised after 20 data bits -> abort: out[0] stays 0xFFFFFFFF, wr = 0000. A following full write of 0xDEADBEEF to 0x81 succeeds.
- wr[1] pending, wr_ack[1] asserted in the same clk as a new completed write to 0x82 -> wr[1] stays 1 and out[1] holds the new data.
